// File: rtl/pwm_duty_meter.sv
// Purpose: measures the high time of N_CH asynchronous PWM inputs over back-to-back windows of 2^WINDOW_EXP cycles.
// Latency: N_SYNC cycles pin-to-sample; the result is presented on the edge that ends the window's last cycle.
// Backpressure: valid/ready output; a window that completes while a result is still held is dropped and flagged in sticky o_overrun.
//
// Ports:
//   i_clk, i_rstn      clock (rising edge) and asynchronous active-low reset
//   i_cg               clock-gate enable; when low every flop holds
//   i_en               measurement enable; low clears the window in progress
//   i_pwm              asynchronous PWM inputs, one bit per channel
//   o_duty/o_valid     per-channel high counts (channel c at [c*WINDOW_EXP +: WINDOW_EXP]) and their valid flag
//   i_ready            consumer accepts o_duty on an edge where o_valid is high
//   i_clrOverrun       clears o_overrun unless a drop happens on the same edge
//   o_overrun          sticky: a completed window's result was discarded
module pwm_duty_meter #(
    parameter int N_CH       = 2,
    parameter int WINDOW_EXP = 8,
    parameter int N_SYNC     = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_cg,
    input  logic                       i_en,
    input  logic [N_CH-1:0]            i_pwm,
    output logic [N_CH*WINDOW_EXP-1:0] o_duty,
    output logic                       o_valid,
    input  logic                       i_ready,
    input  logic                       i_clrOverrun,
    output logic                       o_overrun
);

    localparam logic [WINDOW_EXP-1:0] WC_LAST = '1;
    localparam logic [WINDOW_EXP-1:0] WC_ONE  = WINDOW_EXP'(1);

    // Synchroniser chain: stage 0 samples the pins, the last stage feeds the counters.
    logic [N_SYNC-1:0][N_CH-1:0]     sync_q;
    logic [N_CH-1:0]                 s;

    logic [WINDOW_EXP-1:0]           wc;
    logic [N_CH-1:0][WINDOW_EXP-1:0] cnt;

    // One extra bit so an all-high window (2^WINDOW_EXP) can be detected and clamped.
    logic [N_CH-1:0][WINDOW_EXP:0]   sum;
    logic [N_CH*WINDOW_EXP-1:0]      final_cnt;

    logic                            window_end;
    logic                            load;
    logic                            drop;
    logic                            xfer;

    assign s = sync_q[N_SYNC-1];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '0;
        end else if (i_cg) begin
            sync_q[0] <= i_pwm;
            for (int i = 1; i < N_SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // The sample taken on the window's last cycle is folded in here rather than
    // through cnt, so the counter can restart on the same edge with no gap.
    always_comb begin
        sum       = '0;
        final_cnt = '0;
        for (int c = 0; c < N_CH; c++) begin
            sum[c] = {1'b0, cnt[c]} + (WINDOW_EXP+1)'(s[c]);
            final_cnt[c*WINDOW_EXP +: WINDOW_EXP] =
                sum[c][WINDOW_EXP] ? {WINDOW_EXP{1'b1}} : sum[c][WINDOW_EXP-1:0];
        end
    end

    assign window_end = i_en && (wc == WC_LAST);
    assign xfer       = o_valid && i_ready;
    assign load       = window_end && (!o_valid || i_ready);
    assign drop       = window_end && o_valid && !i_ready;

    // Window counter and per-channel high counters. Disabling throws away the
    // partial window so re-enabling always measures a full one.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wc  <= '0;
            cnt <= '0;
        end else if (i_cg) begin
            if (!i_en) begin
                wc  <= '0;
                cnt <= '0;
            end else begin
                wc <= wc + WC_ONE;
                for (int c = 0; c < N_CH; c++) begin
                    cnt[c] <= window_end ? '0 : cnt[c] + WINDOW_EXP'(s[c]);
                end
            end
        end
    end

    // Output holding register. A load on the same edge as a transfer keeps
    // o_valid high with the new result; a load that would overwrite an
    // unconsumed result is refused and recorded instead.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_duty    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else if (i_cg) begin
            if (load) begin
                o_duty  <= final_cnt;
                o_valid <= 1'b1;
            end else if (xfer) begin
                o_valid <= 1'b0;
            end

            if (drop) begin
                o_overrun <= 1'b1;
            end else if (i_clrOverrun) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Purpose: self-checking bench for pwm_duty_meter (N_CH=2, WINDOW_EXP=4, N_SYNC=2).
// Latency: a reference model predicts o_valid/o_duty/o_overrun per edge; outputs are compared on every falling edge.
// Backpressure: directed scenarios exercise back-to-back windows, held results, drops, clears, reset, enable abort and clock gating.
module tb_pwm_duty_meter;

    localparam int N_CH   = 2;
    localparam int WEXP   = 4;
    localparam int N_SYNC = 2;
    localparam int WLEN   = 1 << WEXP;
    localparam int MAXCNT = WLEN - 1;

    logic                 i_clk = 1'b0;
    logic                 i_rstn = 1'b0;
    logic                 i_cg = 1'b1;
    logic                 i_en = 1'b0;
    logic [N_CH-1:0]      i_pwm = '0;
    logic [N_CH*WEXP-1:0] o_duty;
    logic                 o_valid;
    logic                 i_ready = 1'b0;
    logic                 i_clrOverrun = 1'b0;
    logic                 o_overrun;

    int n_vec = 0;
    int n_err = 0;

    pwm_duty_meter #(
        .N_CH       (N_CH),
        .WINDOW_EXP (WEXP),
        .N_SYNC     (N_SYNC)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_cg         (i_cg),
        .i_en         (i_en),
        .i_pwm        (i_pwm),
        .o_duty       (o_duty),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .i_clrOverrun (i_clrOverrun),
        .o_overrun    (o_overrun)
    );

    initial forever #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    // Pins are remembered as a list of values seen on ungated edges; the value
    // used for counting is the one from N_SYNC ungated edges earlier. A window
    // is simply the list of samples collected while enabled; once it holds
    // WLEN samples its ones are counted and the result is offered.
    logic [N_CH-1:0]      pin_q[$];
    logic [N_CH-1:0]      win[$];
    logic                 m_valid = 1'b0;
    logic                 m_ovr = 1'b0;
    logic [N_CH*WEXP-1:0] m_duty = '0;

    always @(posedge i_clk or negedge i_rstn) begin
        logic [N_CH-1:0] smp;
        logic            loaded;
        logic            dropped;
        int              k;
        if (!i_rstn) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_duty  = '0;
            win.delete();
            pin_q.delete();
            for (int i = 0; i < N_SYNC; i++) pin_q.push_back('0);
        end else if (i_cg) begin
            loaded  = 1'b0;
            dropped = 1'b0;
            smp = pin_q.pop_front();
            pin_q.push_back(i_pwm);
            if (!i_en) begin
                win.delete();
            end else begin
                win.push_back(smp);
                if (win.size() == WLEN) begin
                    if (m_valid && !i_ready) begin
                        dropped = 1'b1;
                    end else begin
                        for (int c = 0; c < N_CH; c++) begin
                            k = 0;
                            foreach (win[i]) k += int'(win[i][c]);
                            if (k > MAXCNT) k = MAXCNT;
                            m_duty[c*WEXP +: WEXP] = WEXP'(k);
                        end
                        loaded = 1'b1;
                    end
                    win.delete();
                end
            end
            if (loaded) m_valid = 1'b1;
            else if (m_valid && i_ready) m_valid = 1'b0;
            if (dropped) m_ovr = 1'b1;
            else if (i_clrOverrun) m_ovr = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        n_vec++;
        if (o_valid !== m_valid || o_duty !== m_duty || o_overrun !== m_ovr) begin
            n_err++;
            $display("FAIL model-compare t=%0t: dut valid=%b duty=%h ovr=%b, model valid=%b duty=%h ovr=%b",
                     $time, o_valid, o_duty, o_overrun, m_valid, m_duty, m_ovr);
        end
    end

    // ---------------- stimulus helpers ----------------
    bit pat_on = 0;
    bit freeze = 0;
    int phase  = 0;

    // ch0: 4 high / 12 low per 16 cycles; ch1: toggles every cycle.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (pat_on && !freeze) phase++;
        if (pat_on) i_pwm = {phase[0], ((phase % 16) < 4)};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Tick until o_valid rises; cyc reports how many edges that took.
    task automatic wait_rise(input int budget, output int cyc);
        logic prev;
        bit   got;
        prev = o_valid;
        got  = 0;
        cyc  = 0;
        while (!got && cyc < budget) begin
            tick();
            cyc++;
            if (o_valid && !prev) got = 1;
            prev = o_valid;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_rise timeout: no o_valid rise within %0d cycles", budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int cyc;

        // Reset state.
        i_pwm = 2'b01;
        @(posedge i_clk);
        #1;
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset duty", 32'(o_duty), 32'd0);
        check("reset overrun", 32'(o_overrun), 32'd0);
        tick();
        i_rstn = 1'b1;

        // 1: constant ch0 high, ch1 low -> ch0 saturates at 15.
        repeat (3) tick();
        i_en = 1'b1;
        i_ready = 1'b1;
        repeat (15) tick();
        check("t1 valid before 16 edges", 32'(o_valid), 32'd0);
        tick();
        check("t1 valid at 16 edges", 32'(o_valid), 32'd1);
        check("t1 duty saturated", 32'(o_duty), 32'h0F);
        wait_rise(40, cyc);
        check("t1 result period", 32'(cyc), 32'd16);
        check("t1 duty second window", 32'(o_duty), 32'h0F);

        // 2: 4/16 on ch0, alternating ch1 -> 4 and 8 each window.
        i_en = 1'b0;
        pat_on = 1;
        phase = 0;
        i_pwm = 2'b01;
        repeat (3) tick();
        i_en = 1'b1;
        wait_rise(40, cyc);
        check("t2 first latency", 32'(cyc), 32'd16);
        check("t2 duty w1", 32'(o_duty), 32'h84);
        wait_rise(40, cyc);
        check("t2 back-to-back period", 32'(cyc), 32'd16);
        check("t2 duty w2", 32'(o_duty), 32'h84);

        // 3: hold the result for 40 cycles; overrun from the second window end.
        tick();
        i_ready = 1'b0;
        wait_rise(40, cyc);
        repeat (15) tick();
        check("t3 overrun before drop", 32'(o_overrun), 32'd0);
        tick();
        check("t3 overrun at drop", 32'(o_overrun), 32'd1);
        repeat (24) tick();
        check("t3 duty held", 32'(o_duty), 32'h84);
        check("t3 valid held", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        tick();
        check("t3 overrun sticky", 32'(o_overrun), 32'd1);
        i_clrOverrun = 1'b1;
        tick();
        i_clrOverrun = 1'b0;
        check("t3 overrun cleared", 32'(o_overrun), 32'd0);

        // 4: ready arrives exactly on the window-end edge.
        i_ready = 1'b0;
        wait_rise(40, cyc);
        repeat (15) tick();
        i_ready = 1'b1;
        tick();
        check("t4 valid stays", 32'(o_valid), 32'd1);
        check("t4 no overrun", 32'(o_overrun), 32'd0);
        check("t4 duty new", 32'(o_duty), 32'h84);
        tick();
        check("t4 valid drops after transfer", 32'(o_valid), 32'd0);

        // 5: asynchronous reset at window cycle 9 while a result is held.
        i_ready = 1'b0;
        wait_rise(40, cyc);
        repeat (9) tick();
        check("t5 valid before reset", 32'(o_valid), 32'd1);
        #2;
        i_rstn = 1'b0;
        #1;
        check("t5 async valid", 32'(o_valid), 32'd0);
        check("t5 async duty", 32'(o_duty), 32'd0);
        check("t5 async overrun", 32'(o_overrun), 32'd0);
        tick();
        i_rstn = 1'b1;
        i_ready = 1'b1;
        wait_rise(40, cyc);
        check("t5 first result after reset", 32'(cyc), 32'd16);

        // 6: enable drop mid-window, then clock gating inside a later window.
        wait_rise(40, cyc);
        repeat (7) tick();
        i_en = 1'b0;
        repeat (2) tick();
        i_en = 1'b1;
        wait_rise(60, cyc);
        check("t6 fresh window after abort", 32'(cyc), 32'd16);
        check("t6 duty after abort", 32'(o_duty), 32'h84);
        repeat (3) tick();
        i_cg = 1'b0;
        freeze = 1;
        repeat (5) tick();
        i_cg = 1'b1;
        freeze = 0;
        wait_rise(40, cyc);
        check("t6 gated window delay", 32'(cyc + 8), 32'd21);
        check("t6 gated duty", 32'(o_duty), 32'h84);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
